// File: rtl/ard_status_tx.sv
// ard_status_tx
// Outbound serial link from the elevator controller to the Arduino. A status
// snapshot (both cars plus hall lamps) is taken on a sendValid/sendReady
// handshake, packed into a 48-bit frame with a rolling sequence number and an
// XOR checksum byte, and shifted out LSB-first on dataOut at BIT_CYCLES clocks
// per bit, followed by GAP_CYCLES idle clocks.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   sendValid  snapshot request (only honoured in IDLE)
//   sendReady  block can accept a snapshot
//   ele1Floor/ele1Dir/ele1Door  elevator 1 status
//   ele2Floor/ele2Dir/ele2Door  elevator 2 status
//   hallLamp   [6:0] up lamps, [13:7] down lamps, floors 0-6
//   dataOut    serial frame data
//   frameSync  high for the whole bit-0 period of each frame
//   busy       high while shifting or in the inter-frame gap
module ard_status_tx #(
    parameter int BIT_CYCLES = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sendValid,
    output logic        sendReady,
    input  logic [2:0]  ele1Floor,
    input  logic [1:0]  ele1Dir,
    input  logic        ele1Door,
    input  logic [2:0]  ele2Floor,
    input  logic [1:0]  ele2Dir,
    input  logic        ele2Door,
    input  logic [13:0] hallLamp,
    output logic        dataOut,
    output logic        frameSync,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    localparam logic [15:0] BIT_LAST = 16'(BIT_CYCLES - 1);
    // GAP state is unreachable when GAP_CYCLES is 0; keep the constant sane.
    localparam logic [15:0] GAP_LAST = 16'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [5:0]  LAST_BIT = 6'd47;

    state_t      r_state;
    logic [47:0] r_shreg;
    logic [5:0]  r_bitIdx;
    logic [15:0] r_cnt;
    logic [15:0] r_gapCnt;
    logic [3:0]  r_seq;
    logic        r_dataOut;
    logic        r_frameSync;
    logic        r_busy;
    logic        r_sendReady;

    logic [1:0]  w_dir1;
    logic [1:0]  w_dir2;
    logic [7:0]  w_b0, w_b1, w_b2, w_b3, w_b4, w_chk;
    logic [47:0] w_frame;

    // Direction code 11 is not a legal direction; it is sent as stop.
    assign w_dir1  = (ele1Dir == 2'b11) ? 2'b00 : ele1Dir;
    assign w_dir2  = (ele2Dir == 2'b11) ? 2'b00 : ele2Dir;

    // Low two bits of bytes 0-2 are a record tag matching the inbound link.
    assign w_b0    = {ele1Door, ele1Floor, w_dir1, 2'b00};
    assign w_b1    = {ele2Door, ele2Floor, w_dir2, 2'b01};
    assign w_b2    = {r_seq, 2'b00, 2'b10};
    assign w_b3    = hallLamp[7:0];
    assign w_b4    = {2'b00, hallLamp[13:8]};
    assign w_chk   = w_b0 ^ w_b1 ^ w_b2 ^ w_b3 ^ w_b4;
    assign w_frame = {w_chk, w_b4, w_b3, w_b2, w_b1, w_b0};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_shreg     <= '0;
            r_bitIdx    <= '0;
            r_cnt       <= '0;
            r_gapCnt    <= '0;
            r_seq       <= '0;
            r_dataOut   <= 1'b0;
            r_frameSync <= 1'b0;
            r_busy      <= 1'b0;
            r_sendReady <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (sendValid) begin
                        // Bit 0 goes out on the acceptance edge itself.
                        r_shreg     <= w_frame;
                        r_dataOut   <= w_frame[0];
                        r_frameSync <= 1'b1;
                        r_busy      <= 1'b1;
                        r_sendReady <= 1'b0;
                        r_bitIdx    <= '0;
                        r_cnt       <= '0;
                        r_state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt       <= '0;
                        r_frameSync <= 1'b0;
                        if (r_bitIdx == LAST_BIT) begin
                            r_seq     <= r_seq + 4'd1;
                            r_dataOut <= 1'b0;
                            if (GAP_CYCLES > 0) begin
                                r_gapCnt <= '0;
                                r_state  <= GAP;
                            end else begin
                                r_busy      <= 1'b0;
                                r_sendReady <= 1'b1;
                                r_state     <= IDLE;
                            end
                        end else begin
                            // Present the next bit in the same edge as the shift.
                            r_shreg   <= {1'b0, r_shreg[47:1]};
                            r_dataOut <= r_shreg[1];
                            r_bitIdx  <= r_bitIdx + 6'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                GAP: begin
                    if (r_gapCnt == GAP_LAST) begin
                        r_busy      <= 1'b0;
                        r_sendReady <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_gapCnt <= r_gapCnt + 16'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign dataOut   = r_dataOut;
    assign frameSync = r_frameSync;
    assign busy      = r_busy;
    // Held low while reset is asserted so it visibly rises on release.
    assign sendReady = r_sendReady & reset;

endmodule
